// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage ALU slice.
// Datapath width is fixed at 32 bits throughout.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int OPW  = 4;

  typedef enum logic [OPW-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } skid_state_e;

  // One buffered result as it travels to the writeback side.
  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [4:0]      rd;
    logic            we;
    logic            illegal;
  } alu_res_t;

endpackage

// File: rtl/alu_addsub.sv
// Two's-complement adder/subtractor; wraps modulo 2^XLEN.
module alu_addsub #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            sub,
  output logic [XLEN-1:0] sum
);

  assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/alu_cmp.sv
// Signed and unsigned less-than comparators.
module alu_cmp #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            lt_s,
  output logic            lt_u
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;

  assign a_s  = a;
  assign b_s  = b;
  assign lt_s = a_s < b_s;
  assign lt_u = a < b;

endmodule

// File: rtl/alu_core.sv
// Combinational ALU: per-function units plus the result select by op code.
// Undefined op codes return zero and flag illegal.
module alu_core #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [OPW-1:0]  op,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  import alu_pkg::*;

  localparam int SHW = $clog2(XLEN);

  logic            is_sub;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] sll_r;
  logic [XLEN-1:0] srl_r;
  logic [XLEN-1:0] sra_r;
  logic [XLEN-1:0] xor_r;
  logic [XLEN-1:0] or_r;
  logic [XLEN-1:0] and_r;
  logic            lt_s;
  logic            lt_u;

  assign is_sub = (op == OP_SUB);

  alu_addsub #(.XLEN(XLEN)) u_addsub (
    .a   (a),
    .b   (b),
    .sub (is_sub),
    .sum (sum)
  );

  alu_shift #(.XLEN(XLEN), .SHW(SHW)) u_shift (
    .a     (a),
    .shamt (b[SHW-1:0]),
    .sll   (sll_r),
    .srl   (srl_r),
    .sra   (sra_r)
  );

  alu_cmp #(.XLEN(XLEN)) u_cmp (
    .a    (a),
    .b    (b),
    .lt_s (lt_s),
    .lt_u (lt_u)
  );

  alu_logic #(.XLEN(XLEN)) u_logic (
    .a     (a),
    .b     (b),
    .xor_r (xor_r),
    .or_r  (or_r),
    .and_r (and_r)
  );

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD,
      OP_SUB:  result = sum;
      OP_SLL:  result = sll_r;
      OP_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
      OP_XOR:  result = xor_r;
      OP_SRL:  result = srl_r;
      OP_SRA:  result = sra_r;
      OP_OR:   result = or_r;
      OP_AND:  result = and_r;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_logic.sv
// Bitwise logic unit.
module alu_logic #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] xor_r,
  output logic [XLEN-1:0] or_r,
  output logic [XLEN-1:0] and_r
);

  assign xor_r = a ^ b;
  assign or_r  = a | b;
  assign and_r = a & b;

endmodule

// File: rtl/alu_shift.sv
// Barrel shifts by a 5-bit amount: logical left/right and arithmetic right.
module alu_shift #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic [XLEN-1:0] a,
  input  logic [SHW-1:0]  shamt,
  output logic [XLEN-1:0] sll,
  output logic [XLEN-1:0] srl,
  output logic [XLEN-1:0] sra
);

  logic signed [XLEN-1:0] a_s;

  assign a_s = a;
  assign sll = a << shamt;
  assign srl = a >> shamt;
  assign sra = a_s >>> shamt;

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: operand-B select, ALU, and a two-entry skid buffer.
// in_ready comes straight from the state register, so out_ready never reaches it.
module ex_alu_stage #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_op,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_illegal
);

  import alu_pkg::*;

  skid_state_e     state;
  skid_state_e     state_nxt;
  logic [XLEN-1:0] op_b_p0;
  logic [XLEN-1:0] alu_res_p0;
  logic            alu_ill_p0;
  alu_res_t        new_p0;
  alu_res_t        main_p1;
  alu_res_t        skid_p1;
  logic            in_fire;
  logic            out_fire;
  logic            load_main_new;
  logic            load_main_skid;
  logic            load_skid;

  // Stage p0: operand select and combinational ALU
  assign op_b_p0 = in_use_imm ? in_imm : in_rs2;

  alu_core #(.XLEN(XLEN), .OPW(OPW)) u_alu (
    .a       (in_rs1),
    .b       (op_b_p0),
    .op      (in_op),
    .result  (alu_res_p0),
    .illegal (alu_ill_p0)
  );

  always_comb begin
    new_p0.result  = alu_res_p0;
    new_p0.rd      = in_rd;
    new_p0.we      = (in_rd != 5'd0) && !alu_ill_p0;
    new_p0.illegal = alu_ill_p0;
  end

  assign in_ready  = (state != S_FULL);
  assign out_valid = (state != S_EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_nxt      = state;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      S_EMPTY: begin
        if (in_fire) begin
          state_nxt     = S_ONE;
          load_main_new = 1'b1;
        end
      end
      S_ONE: begin
        if (in_fire && out_fire) begin
          load_main_new = 1'b1;
        end else if (in_fire) begin
          state_nxt = S_FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (out_fire) begin
          state_nxt      = S_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
    // Flush drops everything, including an operation arriving this cycle.
    if (flush) begin
      state_nxt      = S_EMPTY;
      load_main_new  = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Stage p1: main (output) and skid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      main_p1 <= '0;
      skid_p1 <= '0;
    end else begin
      if (load_main_new) begin
        main_p1 <= new_p0;
      end else if (load_main_skid) begin
        main_p1 <= skid_p1;
      end
      if (load_skid) begin
        skid_p1 <= new_p0;
      end
    end
  end

  assign out_result  = main_p1.result;
  assign out_rd      = main_p1.rd;
  assign out_we      = main_p1.we;
  assign out_illegal = main_p1.illegal;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Scoreboard bench for ex_alu_stage: expected results queued at input transfer,
// compared in order at output transfer, plus directed handshake/flush/reset checks.
module tb_ex_alu_stage;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_illegal;

  int   n_tests;
  int   n_fail;
  logic rand_rdy;
  exp_t sb_q[$];
  exp_t sb_e;

  ex_alu_stage dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_imm      (in_imm),
    .in_use_imm  (in_use_imm),
    .in_rd       (in_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd),
    .out_we      (out_we),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd);
    exp_t        e;
    logic [4:0]  sh;
    logic [63:0] ext;
    sh       = b[4:0];
    ext      = '0;
    e.ill    = 1'b0;
    e.result = '0;
    case (op)
      4'd0: e.result = a + b;
      4'd1: e.result = a + ~b + 32'd1;
      4'd2: e.result = a << sh;
      4'd3: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4: e.result = (a < b) ? 32'd1 : 32'd0;
      4'd5: e.result = a ^ b;
      4'd6: e.result = a >> sh;
      4'd7: begin
        ext      = {{32{a[31]}}, a} >> sh;
        e.result = ext[31:0];
      end
      4'd8: e.result = a | b;
      4'd9: e.result = a & b;
      default: e.ill = 1'b1;
    endcase
    e.rd = rd;
    e.we = (rd != 5'd0) && !e.ill;
    return e;
  endfunction

  // Scoreboard: pop on output transfer, push on input transfer.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          sb_e = sb_q.pop_front();
          check("sb_res", 64'({out_result, out_rd, out_we, out_illegal}), 64'(sb_e));
        end
      end
      if (in_valid && in_ready)
        sb_q.push_back(model(in_op, in_rs1, in_use_imm ? in_imm : in_rs2, in_rd));
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] imm, input logic ui, input logic [4:0] rd);
    int          w;
    logic [31:0] rr;
    in_valid   = 1'b1;
    in_op      = op;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_imm     = imm;
    in_use_imm = ui;
    in_rd      = rd;
    if (rand_rdy) begin
      rr        = $urandom;
      out_ready = rr[0] | rr[1];
    end
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'b1;
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    out_ready = 1'b1;
    w = 0;
    while (sb_q.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pick [6];
    logic [31:0] r;
    logic [31:0] ra;
    logic [31:0] rb;
    n_tests    = 0;
    n_fail     = 0;
    rand_rdy   = 1'b0;
    rst        = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_op      = '0;
    in_rs1     = '0;
    in_rs2     = '0;
    in_imm     = '0;
    in_use_imm = 1'b0;
    in_rd      = '0;
    out_ready  = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_result", 64'(out_result), 64'd0);
    check("rst_rd", 64'(out_rd), 64'd0);
    check("rst_we", 64'(out_we), 64'd0);
    check("rst_illegal", 64'(out_illegal), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ADD overflow wraps, result visible one cycle after transfer
    send(4'd0, 32'h7FFF_FFFF, 32'h0, 32'h1, 1'b1, 5'd3);
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_result", 64'(out_result), 64'h8000_0000);
    check("add_we", 64'(out_we), 64'd1);

    send(4'd7, 32'h8000_0000, 32'h0000_0024, 32'h0, 1'b0, 5'd7);
    check("sra_result", 64'(out_result), 64'hF800_0000);
    send(4'd6, 32'h8000_0000, 32'h0000_0024, 32'h0, 1'b0, 5'd7);
    check("srl_result", 64'(out_result), 64'h0800_0000);

    send(4'd12, 32'h1234_5678, 32'h9, 32'h0, 1'b0, 5'd5);
    check("ill_flag", 64'(out_illegal), 64'd1);
    check("ill_result", 64'(out_result), 64'd0);
    check("ill_we", 64'(out_we), 64'd0);
    send(4'd1, 32'd5, 32'd3, 32'h0, 1'b0, 5'd0);
    check("sub_rd0_we", 64'(out_we), 64'd0);
    check("sub_rd0_result", 64'(out_result), 64'd2);
    drain();

    // Mixed ops on boundary operands with random backpressure
    pick[0] = 32'h0000_0000;
    pick[1] = 32'h0000_0001;
    pick[2] = 32'h7FFF_FFFF;
    pick[3] = 32'h8000_0000;
    pick[4] = 32'hFFFF_FFFF;
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      pick[5] = $urandom;
      r  = $urandom_range(0, 5);
      ra = pick[r];
      r  = $urandom_range(0, 5);
      rb = pick[r];
      r  = $urandom;
      send(r[3:0] % 4'd12, ra, rb, {{27{1'b0}}, r[8:4]}, r[9], r[14:10]);
    end
    rand_rdy = 1'b0;
    in_valid = 1'b0;
    drain();

    // Backpressure fills the skid buffer; drain preserves order
    out_ready = 1'b0;
    send(4'd0, 32'd10, 32'd20, 32'h0, 1'b0, 5'd1);
    send(4'd5, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0, 1'b0, 5'd2);
    @(negedge clk);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_out_valid", 64'(out_valid), 64'd1);
    check("full_head", 64'(out_result), 64'd30);
    repeat (3) @(negedge clk);
    check("stall_stable_res", 64'(out_result), 64'd30);
    check("stall_stable_rd", 64'(out_rd), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("after_drain_ready", 64'(in_ready), 64'd1);
    check("second_result", 64'(out_result), 64'hF00F_F00F);
    drain();

    // Flush while full with an input offered: nothing survives
    out_ready = 1'b0;
    send(4'd8, 32'h1, 32'h2, 32'h0, 1'b0, 5'd4);
    send(4'd9, 32'h3, 32'h6, 32'h0, 1'b0, 5'd4);
    in_valid = 1'b1;
    in_op    = 4'd0;
    in_rs1   = 32'd99;
    in_rd    = 5'd9;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("flush_no_stale", 64'(out_valid), 64'd0);
    end

    // Flush in ONE state discards the same-cycle input transfer
    out_ready = 1'b0;
    send(4'd0, 32'd7, 32'd8, 32'h0, 1'b0, 5'd6);
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_one_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset while full with out_ready toggling
    out_ready = 1'b0;
    send(4'd2, 32'h1, 32'h4, 32'h0, 1'b0, 5'd8);
    send(4'd3, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 5'd8);
    rst       = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("rstfull_out_valid", 64'(out_valid), 64'd0);
    check("rstfull_in_ready", 64'(in_ready), 64'd1);
    check("rstfull_result", 64'(out_result), 64'd0);
    out_ready = 1'b1;
    send(4'd0, 32'd1, 32'd2, 32'h0, 1'b0, 5'd4);
    check("post_rst_result", 64'(out_result), 64'd3);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_alu_stage.md
EX_ALU_STAGE -- requirements
Module: ex_alu_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits; only 32 is supported.
REQ-002 Parameter OPW, default 4, width of the ALU operation code.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 flush  input  1  discard all buffered operations this cycle.
REQ-006 in_valid  input  1  upstream operation present.
REQ-007 in_ready  output  1  stage can accept an operation this cycle.
REQ-008 in_op  input  OPW  ALU operation code per package encoding.
REQ-009 in_rs1  input  XLEN  first operand.
REQ-010 in_rs2  input  XLEN  second register operand.
REQ-011 in_imm  input  XLEN  sign-extended immediate.
REQ-012 in_use_imm  input  1  1: operand B = in_imm, 0: operand B = in_rs2.
REQ-013 in_rd  input  5  destination register index.
REQ-014 out_valid  output  1  result present for downstream.
REQ-015 out_ready  input  1  downstream accepts result this cycle.
REQ-016 out_result  output  XLEN  registered ALU result.
REQ-017 out_rd  output  5  destination index carried with result.
REQ-018 out_we  output  1  write enable; 0 when out_rd == 0 or op illegal.
REQ-019 out_illegal  output  1  op code outside the defined set.

Function
REQ-020 Op encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND; 10-15 illegal.
REQ-021 ADD/SUB wrap modulo 2^32; no overflow flag.
REQ-022 Shifts use B[4:0] only; SRA fills with A[31] (true arithmetic shift); SRL/SLL fill with 0.
REQ-023 SLT compares signed, SLTU unsigned; result 32'h1 or 32'h0.
REQ-024 Illegal op: out_result = 0, out_illegal = 1, out_we = 0.
REQ-025 Input handshake: transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-026 Result computed combinationally from inputs and captured at transfer; latency exactly 1 cycle from input transfer to out_valid.
REQ-027 Two-entry skid buffer: main register (drives outputs) plus skid register.
REQ-028 in_ready = !skid_valid (registered, no combinational path from out_ready).
REQ-029 States: EMPTY (no entries), ONE (main valid), FULL (main+skid valid).
REQ-030 EMPTY: input transfer -> ONE.
REQ-031 ONE: input and output transfer same cycle -> ONE with new data; input only -> FULL if main not drained (data to skid); output only -> EMPTY.
REQ-032 FULL: in_ready = 0; output transfer -> skid moves to main, ONE; otherwise hold.
REQ-033 Ordering strictly FIFO; no operation dropped or duplicated while flush = 0.
REQ-034 Output fields stable while out_valid && !out_ready.
REQ-035 flush: next state EMPTY, both valid bits cleared; any same-cycle input transfer is discarded; flush wins over rst-free concurrent events.

Reset
REQ-036 rst forces EMPTY: out_valid = 0, in_ready = 1 next cycle.
REQ-037 Reset values: out_result = 0, out_rd = 0, out_we = 0, out_illegal = 0, skid data = 0.
REQ-038 rst mid-operation discards all entries; rst has priority over flush and handshakes.

Structure
REQ-039 Package alu_pkg holds XLEN, OPW, op-code constants and the op enum type.
REQ-040 Sub-module alu_core: combinational, inputs a, b, op; outputs result, illegal; instantiates the per-function units.
REQ-041 ex_alu_stage contains only operand-B mux, skid-buffer control and registers.

Verification
REQ-042 ADD rs1=32'h7FFF_FFFF, imm=1, use_imm=1, rd=3 -> next cycle out_result=32'h8000_0000, out_we=1.
REQ-043 SRA rs1=32'h8000_0000, rs2=32'h0000_0024 (shift 4) -> out_result=32'hF800_0000; SRL same -> 32'h0800_0000.
REQ-044 out_ready=0, send ops A,B -> in_ready=0 after B; raise out_ready -> A then B in order, in_ready=1 after A drains.
REQ-045 op=12, rd=5 -> out_illegal=1, out_result=0, out_we=0; SUB with rd=0 -> out_we=0.
REQ-046 FULL state, assert flush with in_valid=1 -> out_valid=0 next cycle, no stale result emitted.
REQ-047 rst asserted while FULL and out_ready toggling -> out_valid=0, in_ready=1 cycle after rst.
